// File: rtl/debug_scan_bridge.sv
// Oversamples a virtual-JTAG port in the clk domain and runs the DR shift register, jdo update and one-hot update pulses.
// Latency: input edge to sr/jdo is SYNC_STAGES+1 clks, to pulse SYNC_STAGES+2; no backpressure, every update is taken.
module debug_scan_bridge #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tck,
  input  logic                        tdi,
  input  logic [IR_W-1:0]             ir_in,
  input  logic                        vs_cdr,
  input  logic                        vs_sdr,
  input  logic                        vs_udr,
  input  logic                        vs_uir,
  input  logic [(2**IR_W)*DATA_W-1:0] cap_data,
  output logic                        tdo,
  output logic [DATA_W-1:0]           jdo,
  output logic [(2**IR_W)-1:0]        take_action,
  output logic [(2**IR_W)-1:0]        take_no_action,
  output logic                        scan_err
);

  localparam int NCH = 2**IR_W;
  localparam int SW  = IR_W + 6;
  localparam int CW  = $clog2(DATA_W + 2);
  localparam int STW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DATA_W);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(DATA_W + 1);
  localparam logic [STW-1:0] ST_DONE  = STW'(SYNC_STAGES + 1);

  logic [SW-1:0]                  w_in;
  logic [SW-1:0]                  w_s;
  logic [SYNC_STAGES-1:0][SW-1:0] r_sync;
  logic [SW-1:0]                  r_d;
  logic [STW-1:0]                 r_st_cnt;
  logic                           w_started;
  logic                           r_tck_rise;
  logic                           r_udr_rise;
  logic                           r_uir_rise;

  logic                           w_tdi_d;
  logic                           w_cdr_d;
  logic                           w_sdr_d;
  logic [IR_W-1:0]                w_ir_d;
  logic [DATA_W-1:0]              w_cap;
  logic [NCH-1:0]                 w_onehot;

  logic [DATA_W-1:0]              r_sr;
  logic [DATA_W-1:0]              r_jdo;
  logic [CW-1:0]                  r_cnt;
  logic [IR_W-1:0]                r_ir_q;
  logic                           r_err;
  logic                           r_pend_vld;
  logic                           r_pend_act;
  logic [IR_W-1:0]                r_pend_ch;
  logic [NCH-1:0]                 r_ta;
  logic [NCH-1:0]                 r_tna;

  assign w_in      = {ir_in, vs_uir, vs_udr, vs_sdr, vs_cdr, tdi, tck};
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_started = (r_st_cnt == ST_DONE);

  // r_d holds the synchronized word of the cycle whose edge is now registered, so data stays aligned with it
  assign w_tdi_d = r_d[1];
  assign w_cdr_d = r_d[2];
  assign w_sdr_d = r_d[3];
  assign w_ir_d  = r_d[6 +: IR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_d        <= '0;
      r_st_cnt   <= '0;
      r_tck_rise <= 1'b0;
      r_udr_rise <= 1'b0;
      r_uir_rise <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], w_in};
      r_d        <= w_s;
      r_tck_rise <= w_started & w_s[0] & ~r_d[0];
      r_udr_rise <= w_started & w_s[4] & ~r_d[4];
      r_uir_rise <= w_started & w_s[5] & ~r_d[5];
      if (!w_started) r_st_cnt <= r_st_cnt + 1'b1;
    end
  end

  always_comb begin
    w_cap = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_ir_q == IR_W'(k)) w_cap = cap_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_onehot = NCH'(1) << r_pend_ch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr       <= '0;
      r_jdo      <= '0;
      r_cnt      <= '0;
      r_ir_q     <= '0;
      r_err      <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_act <= 1'b0;
      r_pend_ch  <= '0;
      r_ta       <= '0;
      r_tna      <= '0;
    end else begin
      r_pend_vld <= 1'b0;
      r_ta       <= '0;
      r_tna      <= '0;
      if (r_pend_vld) begin
        if (r_pend_act) r_ta  <= w_onehot;
        else            r_tna <= w_onehot;
      end
      if (r_tck_rise) begin
        if (w_cdr_d) begin
          r_sr  <= w_cap;
          r_cnt <= '0;
        end else if (w_sdr_d) begin
          r_sr <= {w_tdi_d, r_sr[DATA_W-1:1]};
          if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
        end
      end
      if (r_udr_rise) begin
        r_jdo <= r_sr;
        if (r_cnt == CNT_FULL) begin
          r_pend_vld <= 1'b1;
          r_pend_act <= r_sr[DATA_W-1];
          r_pend_ch  <= r_ir_q;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_uir_rise) begin
        r_ir_q <= w_ir_d;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
    end
  end

  assign tdo            = r_sr[0];
  assign jdo            = r_jdo;
  assign take_action    = r_ta;
  assign take_no_action = r_tna;
  assign scan_err       = r_err;

endmodule

// File: tb/tb_debug_scan_bridge.sv
// Bench for debug_scan_bridge: JTAG-level operations driven slowly against a per-operation DR model.
module tb_debug_scan_bridge;

  localparam int DATA_W      = 38;
  localparam int IR_W        = 2;
  localparam int NCH         = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HOLD        = 6;
  localparam int PULSE_K     = SYNC_STAGES + 2;

  logic                       clk;
  logic                       reset;
  logic                       tck;
  logic                       tdi;
  logic [IR_W-1:0]            ir_in;
  logic                       vs_cdr;
  logic                       vs_sdr;
  logic                       vs_udr;
  logic                       vs_uir;
  logic [NCH-1:0][DATA_W-1:0] cap_arr;
  logic [NCH*DATA_W-1:0]      cap_data;
  logic                       tdo;
  logic [DATA_W-1:0]          jdo;
  logic [NCH-1:0]             take_action;
  logic [NCH-1:0]             take_no_action;
  logic                       scan_err;

  assign cap_data = cap_arr;

  debug_scan_bridge #(.DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .tck(tck), .tdi(tdi), .ir_in(ir_in),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .cap_data(cap_data), .tdo(tdo), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action), .scan_err(scan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: DR contents, bit count, latched IR, last update word, sticky error.
  logic [DATA_W-1:0] m_sr;
  logic [DATA_W-1:0] m_jdo;
  int                m_cnt;
  int                m_ir;
  bit                m_err;

  function automatic void model_reset();
    m_sr = '0; m_jdo = '0; m_cnt = 0; m_ir = 0; m_err = 1'b0;
  endfunction

  function automatic void model_uir(input int ir);
    m_ir = ir; m_cnt = 0; m_err = 1'b0;
  endfunction

  function automatic void model_cdr();
    m_sr = cap_arr[m_ir]; m_cnt = 0;
  endfunction

  function automatic void model_shift(input logic b);
    m_sr = {b, m_sr[DATA_W-1:1]};
    if (m_cnt < DATA_W + 1) m_cnt++;
  endfunction

  task automatic model_udr(output bit exp_pulse, output logic [NCH-1:0] exp_ta, output logic [NCH-1:0] exp_tna);
    logic [NCH-1:0] oh;
    oh = NCH'(1) << m_ir;
    exp_pulse = 1'b0; exp_ta = '0; exp_tna = '0;
    m_jdo = m_sr;
    if (m_cnt == DATA_W) begin
      exp_pulse = 1'b1;
      if (m_sr[DATA_W-1]) exp_ta = oh;
      else                exp_tna = oh;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv_uir(input logic [IR_W-1:0] ir);
    ir_in = ir; wait_clk(2);
    vs_uir = 1'b1; wait_clk(HOLD);
    vs_uir = 1'b0; wait_clk(HOLD);
  endtask

  task automatic drv_cdr();
    vs_cdr = 1'b1; wait_clk(2);
    tck = 1'b1; wait_clk(HOLD);
    tck = 1'b0; wait_clk(HOLD);
    vs_cdr = 1'b0; wait_clk(2);
  endtask

  task automatic drv_shift(input logic b, output logic t);
    tdi = b; vs_sdr = 1'b1; wait_clk(2);
    t = tdo;
    tck = 1'b1; wait_clk(HOLD);
    tck = 1'b0; wait_clk(HOLD);
    vs_sdr = 1'b0;
  endtask

  task automatic drv_udr(output logic [DATA_W-1:0] jdo_early, output logic [DATA_W-1:0] jdo_ontime,
                         output int n_pulse, output int pulse_k,
                         output logic [NCH-1:0] ta_obs, output logic [NCH-1:0] tna_obs, output int multi);
    n_pulse = 0; pulse_k = -1; ta_obs = '0; tna_obs = '0; multi = 0;
    jdo_early = '0; jdo_ontime = '0;
    vs_udr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == SYNC_STAGES)     jdo_early  = jdo;
      if (k == SYNC_STAGES + 1) jdo_ontime = jdo;
      if ((take_action | take_no_action) != '0) begin
        if (n_pulse == 0) begin
          pulse_k = k; ta_obs = take_action; tna_obs = take_no_action;
        end
        n_pulse++;
      end
      if ($countones(take_action | take_no_action) > 1) multi++;
    end
    vs_udr = 1'b0; wait_clk(HOLD);
  endtask

  task automatic test_reset();
    reset = 1'b1; tdi = 1'b1; vs_sdr = 1'b1; ir_in = 2'b11;
    cap_arr = '1;
    wait_clk(4); tck = 1'b1; wait_clk(4); tck = 1'b0; wait_clk(3);
    n_total++; if (tdo !== 1'b0) $display("FAIL reset_tdo: got %b want 0", tdo); else n_pass++;
    n_total++; if (jdo !== '0) $display("FAIL reset_jdo: got %h want 0", jdo); else n_pass++;
    n_total++; if ((take_action | take_no_action) !== '0)
      $display("FAIL reset_pulse: got %b/%b want 0", take_action, take_no_action); else n_pass++;
    n_total++; if (scan_err !== 1'b0) $display("FAIL reset_err: got %b want 0", scan_err); else n_pass++;
    vs_sdr = 1'b0; tdi = 1'b0; cap_arr = '0;
    reset = 1'b0; wait_clk(HOLD);
    model_reset();
  endtask

  task automatic test_action();
    logic [DATA_W-1:0] pat, je, jo, obs_word;
    logic [NCH-1:0] ta, tna, eta, etna;
    logic t;
    int np, pk, mh;
    bit ep;
    pat = 38'h20_0000_00AB;
    cap_arr[2] = DATA_W'({$urandom(), $urandom()});
    drv_uir(2'd2); model_uir(2);
    drv_cdr(); model_cdr();
    for (int i = 0; i < DATA_W; i++) begin
      drv_shift(pat[i], t); obs_word[i] = t; model_shift(pat[i]);
    end
    n_total++; if (obs_word !== cap_arr[2]) $display("FAIL action_tdo_stream: got %h want %h", obs_word, cap_arr[2]); else n_pass++;
    drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
    n_total++; if (je !== '0) $display("FAIL action_jdo_early: got %h want 0", je); else n_pass++;
    n_total++; if (jo !== pat) $display("FAIL action_jdo_latency: got %h want %h", jo, pat); else n_pass++;
    n_total++; if (jdo !== pat) $display("FAIL action_jdo: got %h want %h", jdo, pat); else n_pass++;
    n_total++; if (np !== 1) $display("FAIL action_pulse_count: got %0d want 1", np); else n_pass++;
    n_total++; if (pk !== PULSE_K) $display("FAIL action_pulse_cycle: got %0d want %0d", pk, PULSE_K); else n_pass++;
    n_total++; if (ta !== 4'b0100) $display("FAIL action_take_action: got %b want 0100", ta); else n_pass++;
    n_total++; if (tna !== etna) $display("FAIL action_take_no_action: got %b want %b", tna, etna); else n_pass++;
    n_total++; if (scan_err !== 1'b0) $display("FAIL action_err: got %b want 0", scan_err); else n_pass++;
  endtask

  task automatic test_capture_tdo();
    logic [DATA_W-1:0] je, jo, obs_word, want;
    logic [NCH-1:0] ta, tna, eta, etna;
    logic t;
    int np, pk, mh;
    bit ep;
    want = 38'h0_1234_5678;
    cap_arr[1] = want;
    drv_uir(2'd1); model_uir(1);
    drv_cdr(); model_cdr();
    for (int i = 0; i < DATA_W; i++) begin
      drv_shift(1'b0, t); obs_word[i] = t; model_shift(1'b0);
    end
    n_total++; if (obs_word !== want) $display("FAIL capture_tdo_stream: got %h want %h", obs_word, want); else n_pass++;
    drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
    n_total++; if (jdo !== '0) $display("FAIL capture_jdo: got %h want 0", jdo); else n_pass++;
    n_total++; if (tna !== 4'b0010 || ta !== 4'b0000 || np !== 1)
      $display("FAIL capture_pulse: got ta=%b tna=%b n=%0d want ta=0000 tna=0010 n=1", ta, tna, np); else n_pass++;
  endtask

  task automatic test_short_scan();
    logic [DATA_W-1:0] je, jo;
    logic [NCH-1:0] ta, tna, eta, etna;
    logic t, b;
    logic [IR_W-1:0] ir;
    int np, pk, mh;
    bit ep;
    ir = IR_W'($urandom_range(0, NCH-1));
    cap_arr[ir] = DATA_W'({$urandom(), $urandom()});
    drv_uir(ir); model_uir(int'(ir));
    drv_cdr(); model_cdr();
    for (int i = 0; i < DATA_W - 1; i++) begin
      b = 1'($urandom()); drv_shift(b, t); model_shift(b);
    end
    drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
    n_total++; if (scan_err !== 1'b1) $display("FAIL short_err: got %b want 1", scan_err); else n_pass++;
    n_total++; if (np !== 0) $display("FAIL short_no_pulse: got %0d pulses want 0", np); else n_pass++;
    n_total++; if (jdo !== m_jdo) $display("FAIL short_jdo: got %h want %h", jdo, m_jdo); else n_pass++;
    drv_uir(ir); model_uir(int'(ir));
    n_total++; if (scan_err !== 1'b0) $display("FAIL short_err_clear: got %b want 0", scan_err); else n_pass++;
  endtask

  task automatic test_release_levels();
    logic [DATA_W-1:0] je, jo;
    logic [NCH-1:0] ta, tna, eta, etna;
    int np, pk, mh, seen;
    bit ep;
    reset = 1'b1; wait_clk(2);
    tck = 1'b1; vs_udr = 1'b1; vs_sdr = 1'b1; tdi = 1'b1; wait_clk(3);
    reset = 1'b0; model_reset();
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((take_action | take_no_action) != '0) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL release_no_pulse: got %0d pulse cycles want 0", seen); else n_pass++;
    n_total++; if (jdo !== '0) $display("FAIL release_jdo: got %h want 0", jdo); else n_pass++;
    n_total++; if (scan_err !== 1'b0) $display("FAIL release_err: got %b want 0", scan_err); else n_pass++;
    tck = 1'b0; wait_clk(HOLD);
    vs_sdr = 1'b0; vs_udr = 1'b0; tdi = 1'b0; wait_clk(HOLD);
    drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
    n_total++; if (jdo !== '0) $display("FAIL release_no_shift: got jdo %h want 0", jdo); else n_pass++;
    n_total++; if (scan_err !== m_err) $display("FAIL release_udr_err: got %b want %b", scan_err, m_err); else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    logic [DATA_W-1:0] je, jo;
    logic [NCH-1:0] ta, tna, eta, etna;
    logic t, b;
    int np, pk, mh;
    bit ep;
    cap_arr[3] = DATA_W'({$urandom(), $urandom()});
    drv_uir(2'd3); model_uir(3);
    drv_cdr(); model_cdr();
    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom()); drv_shift(b, t); model_shift(b);
    end
    reset = 1'b1; wait_clk(3); reset = 1'b0; wait_clk(HOLD); model_reset();
    drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
    n_total++; if (scan_err !== 1'b1) $display("FAIL midreset_err: got %b want 1", scan_err); else n_pass++;
    n_total++; if (np !== 0) $display("FAIL midreset_no_pulse: got %0d want 0", np); else n_pass++;
    n_total++; if (jdo !== '0) $display("FAIL midreset_jdo: got %h want 0", jdo); else n_pass++;
    // a full 38-bit scan from here only pulses if the count restarted at zero
    for (int i = 0; i < DATA_W; i++) begin
      b = 1'($urandom()); drv_shift(b, t); model_shift(b);
    end
    drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
    n_total++; if (np !== 1 || ta !== eta || tna !== etna)
      $display("FAIL midreset_full_scan: got n=%0d ta=%b tna=%b want n=1 ta=%b tna=%b", np, ta, tna, eta, etna); else n_pass++;
  endtask

  task automatic test_cdr_sdr_same();
    logic [DATA_W-1:0] je, jo, obs_word, want;
    logic [NCH-1:0] ta, tna, eta, etna;
    logic t, b;
    logic [IR_W-1:0] ir;
    int np, pk, mh;
    bit ep;
    ir = IR_W'($urandom_range(0, NCH-1));
    cap_arr[ir] = DATA_W'({$urandom(), $urandom()});
    want = cap_arr[ir];
    drv_uir(ir); model_uir(int'(ir));
    vs_cdr = 1'b1; vs_sdr = 1'b1; tdi = 1'b1; wait_clk(2);
    tck = 1'b1; wait_clk(HOLD); tck = 1'b0; wait_clk(HOLD);
    vs_cdr = 1'b0; vs_sdr = 1'b0; wait_clk(2);
    model_cdr();
    for (int i = 0; i < DATA_W; i++) begin
      b = 1'($urandom()); drv_shift(b, t); obs_word[i] = t; model_shift(b);
    end
    n_total++; if (obs_word !== want) $display("FAIL both_capture_wins: got %h want %h", obs_word, want); else n_pass++;
    drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
    n_total++; if (np !== 1) $display("FAIL both_cnt_zero: got %0d pulses want 1", np); else n_pass++;
    n_total++; if (jdo !== m_jdo) $display("FAIL both_jdo: got %h want %h", jdo, m_jdo); else n_pass++;
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] je, jo;
    logic [63:0] obs_word, exp_word;
    logic [NCH-1:0] ta, tna, eta, etna;
    logic t, b;
    logic [IR_W-1:0] ir;
    int np, pk, mh, nbits;
    bit ep;
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < NCH; c++) cap_arr[c] = DATA_W'({$urandom(), $urandom()});
      if (it == 0 || $urandom_range(0, 2) != 0) begin
        ir = IR_W'($urandom_range(0, NCH-1));
        drv_uir(ir); model_uir(int'(ir));
      end
      if ($urandom_range(0, 3) != 0) begin
        drv_cdr(); model_cdr();
      end
      nbits = ($urandom_range(0, 1) == 1) ? DATA_W : (DATA_W - 2 + $urandom_range(0, 4));
      obs_word = '0; exp_word = '0;
      for (int i = 0; i < nbits; i++) begin
        b = 1'($urandom());
        exp_word[i] = m_sr[0];
        drv_shift(b, t); obs_word[i] = t; model_shift(b);
      end
      n_total++; if (obs_word !== exp_word) $display("FAIL rand%0d_tdo: got %h want %h", it, obs_word, exp_word); else n_pass++;
      drv_udr(je, jo, np, pk, ta, tna, mh); model_udr(ep, eta, etna);
      n_total++; if (jdo !== m_jdo) $display("FAIL rand%0d_jdo: got %h want %h", it, jdo, m_jdo); else n_pass++;
      n_total++; if (np !== (ep ? 1 : 0) || ta !== eta || tna !== etna)
        $display("FAIL rand%0d_pulse: got n=%0d ta=%b tna=%b want n=%0d ta=%b tna=%b", it, np, ta, tna, ep ? 1 : 0, eta, etna); else n_pass++;
      if (ep) begin
        n_total++; if (pk !== PULSE_K) $display("FAIL rand%0d_pulse_cycle: got %0d want %0d", it, pk, PULSE_K); else n_pass++;
      end
      n_total++; if (mh !== 0) $display("FAIL rand%0d_onehot: got %0d multi-hot cycles want 0", it, mh); else n_pass++;
      n_total++; if (scan_err !== m_err) $display("FAIL rand%0d_err: got %b want %b", it, scan_err, m_err); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; tck = 1'b0; tdi = 1'b0; ir_in = '0;
    vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0;
    cap_arr = '0;
    model_reset();
    test_reset();
    test_action();
    test_capture_tdo();
    test_short_scan();
    test_release_levels();
    test_reset_mid_scan();
    test_cdr_sdr_same();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debug_scan_bridge.md
DEBUG_SCAN_BRIDGE -- requirements
Module: debug_scan_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 38: scan register and jdo width (>=2).
REQ-002 SHALL have parameter IR_W, default 2: instruction width; NCH = 2**IR_W channels.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth (>=2).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk and reset; every flop is clocked by clk.
REQ-005 SHALL have port clk, input, 1: system clock.
REQ-006 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port tck, input, 1: JTAG clock, asynchronous to clk, sampled as data.
REQ-008 SHALL have port tdi, input, 1: serial scan data in, asynchronous.
REQ-009 SHALL have port ir_in, input, IR_W: virtual IR value, asynchronous.
REQ-010 SHALL have ports vs_cdr, vs_sdr, vs_udr, vs_uir, input, 1 each: capture/shift/update-DR and update-IR levels, asynchronous.
REQ-011 SHALL have port cap_data, input, NCH*DATA_W: per-channel capture words, channel k at [k*DATA_W +: DATA_W].
REQ-012 SHALL have port tdo, output, 1: serial data out, equal to sr[0].
REQ-013 SHALL have port jdo, output, DATA_W: last updated scan word.
REQ-014 SHALL have ports take_action and take_no_action, output, NCH each: one-hot single-cycle update pulses.
REQ-015 SHALL have port scan_err, output, 1: sticky flag for a short or long DR scan.

Function
REQ-016 SHALL pass tck, tdi, ir_in and the vs_* inputs through SYNC_STAGES flops each; all logic SHALL use only the synchronized copies.
REQ-017 SHALL detect rising edges of synchronized tck, vs_udr and vs_uir against a registered previous value.
REQ-018 SHALL ignore all detected edges for SYNC_STAGES+1 clk cycles after reset deasserts (startup counter), so a level already high at release produces no edge.
REQ-019 On a tck rising edge with cdr_s=1, SHALL load sr from the cap_data slice selected by ir_q and clear bit counter cnt to 0.
REQ-020 On a tck rising edge with sdr_s=1 and cdr_s=0, SHALL shift right with sr <= {tdi_s, sr[DATA_W-1:1]} and increment cnt, saturating at DATA_W+1.
REQ-021 If cdr_s and sdr_s are both high on the same tck edge, capture SHALL win.
REQ-022 On a vs_uir rising edge, SHALL set ir_q <= ir_s, cnt <= 0 and scan_err <= 0.
REQ-023 On a vs_udr rising edge, SHALL set jdo <= sr, using the pre-shift sr if a tck edge occurs in the same cycle.
REQ-024 On a vs_udr rising edge with cnt == DATA_W, SHALL pulse for exactly one cycle, on the next clk: take_action[ir_q] if sr[DATA_W-1]=1, otherwise take_no_action[ir_q].
REQ-025 On a vs_udr rising edge with cnt != DATA_W, SHALL update jdo, set scan_err=1 and emit no pulse.
REQ-026 At most one bit of take_action|take_no_action SHALL be high in any cycle.
REQ-027 Latency: an input rising edge sampled at clk N SHALL produce its sr/jdo effect at N+SYNC_STAGES+1 and its pulse at N+SYNC_STAGES+2.
REQ-028 tdo SHALL be driven directly from the sr[0] flop, with no combinational path from any input.

Reset
REQ-029 While reset=1, SHALL hold sr, jdo, cnt, ir_q, all synchronizer and edge flops, and the startup counter at 0.
REQ-030 While reset=1, SHALL hold tdo, take_action, take_no_action and scan_err at 0.
REQ-031 A reset asserted mid-scan SHALL discard the partial scan; after release, the next scan SHALL begin only with a new uir/cdr sequence.

Verification
REQ-032 Use DATA_W=38, IR_W=2. Do uir with ir_in=2, cdr, shift 38 bits of 38'h20_0000_00AB, then udr -> jdo=38'h20_0000_00AB; take_action=4'b0100 for one cycle at udr-sync+2.
REQ-033 Put cap_data channel 1 = 38'h0_1234_5678, do uir ir=1, cdr, then 38 shifts with tdi=0 -> tdo sequence LSB-first is 0x12345678; jdo=0; take_no_action=4'b0010.
REQ-034 Shift 37 bits, then udr -> scan_err=1, no pulse, jdo updated; a following uir -> scan_err=0.
REQ-035 Hold tck=1 and vs_udr=1 through reset release -> no shift, no pulse, jdo stays 0.
REQ-036 Assert reset after 20 shifts, release, then udr without a new cdr -> cnt=0, scan_err=1, no pulse.
REQ-037 Raise cdr_s and sdr_s on the same tck edge -> sr equals the capture value, cnt=0.
